// File: rtl/la_clkgate_pkg.sv
// rtl/la_clkgate_pkg.sv - channel state encoding and saturating-increment helper for la_clkgate_ctrl
package la_clkgate_pkg;

   localparam int STATE_W   = 2;
   localparam int SAT_MAX_W = 32;

   typedef enum logic [STATE_W-1:0] {
      OFF  = 2'd0,
      ON   = 2'd1,
      HOLD = 2'd2
   } chan_state_e;

   // Counters narrower than SAT_MAX_W are zero-extended in and truncated out by the caller.
   function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] val,
                                                    input int unsigned            width);
      logic [SAT_MAX_W-1:0] max_v;
      max_v = (width >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << width) - SAT_MAX_W'(1));
      return (val == max_v) ? val : val + SAT_MAX_W'(1);
   endfunction

endpackage

// File: rtl/la_clkgate_chan.sv
// rtl/la_clkgate_chan.sv - one gated channel: OFF/ON/HOLD FSM, idle-hold counter, ICG cell,
// and an enabled-cycle counter when LA_CLKGATE_STATS_EN is defined
module la_clkgate_chan
   import la_clkgate_pkg::*;
#(
   parameter int HOLD_W = 4,
   parameter int STAT_W = 16,
   parameter     PROP   = "DEFAULT"
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              te_i,
   input  logic              req_i,
   input  logic              force_on_i,
   input  logic [HOLD_W-1:0] cfg_hold_i,
   input  logic              stat_clr_i,
   output logic              eclk_o,
   output logic              on_o,
   output logic [STAT_W-1:0] stat_o
);

   chan_state_e       state_q, state_d;
   logic [HOLD_W-1:0] cnt_q, cnt_d;
   logic              en_q, en_d;
   logic              act;
   logic              hold_done;

   assign act = req_i | force_on_i;
   // Compare cnt+1 against the live limit so a lowered or zeroed cfg_hold exits at once.
   assign hold_done = ({1'b0, cnt_q} + (HOLD_W+1)'(1)) >= {1'b0, cfg_hold_i};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         OFF: begin
            if (act) state_d = ON;
         end
         ON: begin
            if (!act) begin
               state_d = (cfg_hold_i == '0) ? OFF : HOLD;
               cnt_d   = '0;
            end
         end
         HOLD: begin
            if (act) begin
               state_d = ON;
               cnt_d   = '0;
            end else if (hold_done) begin
               state_d = OFF;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + HOLD_W'(1);
            end
         end
         default: begin
            state_d = OFF;
            cnt_d   = '0;
         end
      endcase
      en_d = (state_d != OFF);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= OFF;
         cnt_q   <= '0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
      end
   end

   assign on_o = en_q;

`ifdef LA_CLKGATE_STATS_EN
   logic [STAT_W-1:0] stat_q, stat_d;

   always_comb begin
      stat_d = stat_q;
      if (stat_clr_i) begin
         stat_d = '0;
      end else if (en_q) begin
         stat_d = STAT_W'(sat_inc(SAT_MAX_W'(stat_q), unsigned'(STAT_W)));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) stat_q <= '0;
      else       stat_q <= stat_d;
   end

   assign stat_o = stat_q;
`else
   logic unused_stat_clr;
   assign unused_stat_clr = stat_clr_i;
   assign stat_o          = '0;
`endif

   la_clkicgand #(
      .PROP(PROP)
   ) u_icg (
      .clk_i (clk_i),
      .te_i  (te_i),
      .en_i  (en_q),
      .eclk_o(eclk_o)
   );

endmodule

// File: rtl/la_clkicgand.sv
// rtl/la_clkicgand.sv - latch-based AND clock-gating cell; te forces the gated clock on
module la_clkicgand #(
   parameter PROP = "DEFAULT"
) (
   input  logic clk_i,
   input  logic te_i,
   input  logic en_i,
   output logic eclk_o
);

   logic en_lat_q;

   if (PROP == "DEFAULT") begin : g_cell
      always_latch begin
         if (!clk_i) en_lat_q <= en_i | te_i;
      end
   end else begin : g_cell
      // Library-specific PROP values map to the same behavioural cell outside synthesis.
      always_latch begin
         if (!clk_i) en_lat_q <= en_i | te_i;
      end
   end

   assign eclk_o = clk_i & en_lat_q;

endmodule

// File: rtl/la_clkgate_ctrl.sv
// rtl/la_clkgate_ctrl.sv - N-channel clock-gating controller with idle hysteresis;
// LA_CLKGATE_STATS_EN adds saturating per-channel enabled-cycle counters
module la_clkgate_ctrl
   import la_clkgate_pkg::*;
#(
   parameter int N      = 4,
   parameter int HOLD_W = 4,
   parameter int STAT_W = 16,
   parameter     PROP   = "DEFAULT"
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                te,
   input  logic [N-1:0]        req,
   input  logic [N-1:0]        force_on,
   input  logic [HOLD_W-1:0]   cfg_hold,
   input  logic                stat_clr,
   output logic [N-1:0]        eclk,
   output logic [N-1:0]        on,
   output logic [N*STAT_W-1:0] stat
);

   for (genvar i = 0; i < N; i++) begin : g_chan
      la_clkgate_chan #(
         .HOLD_W(HOLD_W),
         .STAT_W(STAT_W),
         .PROP  (PROP)
      ) u_chan (
         .clk_i     (clk),
         .rst_i     (rst),
         .te_i      (te),
         .req_i     (req[i]),
         .force_on_i(force_on[i]),
         .cfg_hold_i(cfg_hold),
         .stat_clr_i(stat_clr),
         .eclk_o    (eclk[i]),
         .on_o      (on[i]),
         .stat_o    (stat[i*STAT_W +: STAT_W])
      );
   end

endmodule
